// File: rtl/seq101_pkg.sv
// Shared types for the "101" serial scheduler: controller and detector states.
package seq101_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2
  } det_state_t;

endpackage

// File: rtl/seq101_sched_if.sv
// Word-in / count-out handshake bundle plus the serial scan observation signals.
interface seq101_sched_if #(
  parameter int W = 16
);
  localparam int CW = $clog2(W + 1);

  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  data_i;
  logic          overlap_i;
  logic          bit_o;
  logic          bit_valid_o;
  logic          det_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [CW-1:0] count_o;

  modport slave (
    input  in_valid_i, data_i, overlap_i, out_ready_i,
    output in_ready_o, bit_o, bit_valid_o, det_o, out_valid_o, count_o
  );

  modport master (
    output in_valid_i, data_i, overlap_i, out_ready_i,
    input  in_ready_o, bit_o, bit_valid_o, det_o, out_valid_o, count_o
  );
endinterface

// File: rtl/seq101_det.sv
// Mealy "101" detector; overlap_i selects whether a match's final 1 may start the next one.
module seq101_det
  import seq101_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic overlap_i,
  input  logic x_i,
  output logic y_o
);

  det_state_t st, st_nxt;

  // State register: cleared on reset or word start, steps only while scanning.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) st <= D0;
    else if (en_i)      st <= st_nxt;
  end

  // Next-state: prefix tracking for "101".
  always_comb begin
    st_nxt = st;
    case (st)
      D0:      st_nxt = x_i ? D1 : D0;
      D1:      st_nxt = x_i ? D1 : D2;
      D2:      st_nxt = x_i ? (overlap_i ? D1 : D0) : D0;
      default: st_nxt = D0;
    endcase
  end

  // Mealy output: the 1 that completes "10" is the detection.
  always_comb begin
    y_o = en_i && (st == D2) && x_i;
  end

endmodule

// File: rtl/seq101_sched.sv
// Word-to-serial scheduler sharing one "101" detector across successive words.
module seq101_sched
  import seq101_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  seq101_sched_if.slave  bus
);

  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(W);

  ctrl_state_t   state, state_nxt;
  logic [W-1:0]  shreg;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic          mode;
  logic          accept;
  logic          scan;
  logic          bit_s;
  logic          det;

  assign accept = (state == IDLE) && bus.in_valid_i;
  assign scan   = (state == SHIFT);
  assign bit_s  = scan & shreg[W-1];

  seq101_det u_det (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (accept),
    .en_i      (scan),
    .overlap_i (mode),
    .x_i       (bit_s),
    .y_o       (det)
  );

  // Controller state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Controller next-state: accept, scan W bits, hold count until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid_i)  state_nxt = SHIFT;
      SHIFT:   if (idx == '0)       state_nxt = DONE;
      DONE:    if (bus.out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Controller outputs decoded from state.
  always_comb begin
    bus.in_ready_o  = (state == IDLE);
    bus.bit_valid_o = scan;
    bus.bit_o       = bit_s;
    bus.det_o       = det;
    bus.out_valid_o = (state == DONE);
    bus.count_o     = count;
  end

  // Datapath: load on accept, shift/count while scanning; everything else holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg <= '0;
      idx   <= '0;
      count <= '0;
      mode  <= 1'b0;
    end else if (accept) begin
      shreg <= bus.data_i;
      idx   <= IW'(W - 1);
      count <= '0;
      mode  <= bus.overlap_i;
    end else if (scan) begin
      shreg <= {shreg[W-2:0], 1'b0};
      idx   <= idx - IW'(1);
      count <= count + CW'(det);
    end
  end

endmodule

// File: tb/tb_seq101_sched.sv
// Directed bench for seq101_sched with a substring-matching reference model.
module tb_seq101_sched;
  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq101_sched_if #(.W(W)) bus ();

  seq101_sched #(.W(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Detection steps by scanning the word as a bit string: a step k is a hit when
  // steps k-2..k read 1,0,1; non-overlapping hits must start after the previous hit.
  function automatic logic [W-1:0] model_dets(input logic [W-1:0] w, input logic ov);
    logic [W-1:0] v;
    int last;
    v = '0;
    last = -100;
    for (int k = 2; k < W; k++) begin
      if (w[W-1-(k-2)] && !w[W-1-(k-1)] && w[W-1-k] && (ov || (k - 2 > last))) begin
        v[k] = 1'b1;
        last = k;
      end
    end
    return v;
  endfunction

  // Model: m_pos = -1 waiting, 0..W-1 scan step, W holding the result.
  int           m_pos = -1;
  int           m_cnt = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_dvec = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = -1;
      m_cnt = 0;
    end else if (m_pos < 0) begin
      if (bus.in_valid_i) begin
        m_word = bus.data_i;
        m_dvec = model_dets(bus.data_i, bus.overlap_i);
        m_pos  = 0;
        m_cnt  = 0;
      end
    end else if (m_pos < W) begin
      m_cnt = m_cnt + int'(m_dvec[m_pos]);
      m_pos = m_pos + 1;
    end else if (bus.out_ready_i) begin
      m_pos = -1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int e_rdy, e_bv, e_bit, e_det, e_ov;
      e_rdy = (m_pos < 0) ? 1 : 0;
      e_bv  = (m_pos >= 0 && m_pos < W) ? 1 : 0;
      e_bit = e_bv ? int'(m_word[W-1-m_pos]) : 0;
      e_det = e_bv ? int'(m_dvec[m_pos]) : 0;
      e_ov  = (m_pos == W) ? 1 : 0;
      chk("cyc in_ready",  int'(bus.in_ready_o),  e_rdy);
      chk("cyc bit_valid", int'(bus.bit_valid_o), e_bv);
      chk("cyc bit",       int'(bus.bit_o),       e_bit);
      chk("cyc det",       int'(bus.det_o),       e_det);
      chk("cyc out_valid", int'(bus.out_valid_o), e_ov);
      chk("cyc count",     int'(bus.count_o),     m_cnt);
    end
  end

  task automatic run_word(input logic [W-1:0] w, input logic ov, input int exp_cnt,
                          input logic [W-1:0] exp_vec, input string nm);
    logic [W-1:0] obs;
    @(negedge clk);
    chk({nm, " ready"}, int'(bus.in_ready_o), 1);
    bus.in_valid_i = 1'b1;
    bus.data_i     = w;
    bus.overlap_i  = ov;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.data_i     = ~w;
    bus.overlap_i  = ~ov;
    obs = '0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      obs[k] = bus.det_o;
    end
    chk({nm, " det steps"}, int'(obs), int'(exp_vec));
    @(negedge clk);
    chk({nm, " out_valid"}, int'(bus.out_valid_o), 1);
    chk({nm, " count"},     int'(bus.count_o),     exp_cnt);
  endtask

  initial begin
    int acc_cyc[3];
    int acc_n;
    bus.in_valid_i  = 1'b0;
    bus.data_i      = '0;
    bus.overlap_i   = 1'b0;
    bus.out_ready_i = 1'b1;

    // Pin the reference model with hand-derived step vectors.
    chk("model AAAA ovl",   int'(model_dets(16'hAAAA, 1'b1)), int'(16'h5554));
    chk("model AAAA noovl", int'(model_dets(16'hAAAA, 1'b0)), int'(16'h4444));
    chk("model A5A5",       int'(model_dets(16'hA5A5, 1'b0)), int'(16'h8484));
    chk("model 5555 ovl",   int'(model_dets(16'h5555, 1'b1)), int'(16'hAAA8));

    // Reset
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready",  int'(bus.in_ready_o),  1);
    chk("rst count",     int'(bus.count_o),     0);
    chk("rst out_valid", int'(bus.out_valid_o), 0);
    chk("rst bit_valid", int'(bus.bit_valid_o), 0);

    // Main function
    run_word(16'hAAAA, 1'b1, 7, 16'h5554, "AAAA ovl");
    run_word(16'hAAAA, 1'b0, 4, 16'h4444, "AAAA noovl");
    run_word(16'h0000, 1'b1, 0, 16'h0000, "0000");
    run_word(16'hFFFF, 1'b1, 0, 16'h0000, "FFFF");
    run_word(16'hA5A5, 1'b1, 4, 16'h8484, "A5A5 ovl");
    run_word(16'hA5A5, 1'b0, 4, 16'h8484, "A5A5 noovl");

    // Backpressure in DONE, with an ignored word offered meanwhile
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.data_i      = 16'hA5A5;
    bus.overlap_i   = 1'b0;
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    for (int k = 0; k < W; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp out_valid", int'(bus.out_valid_o), 1);
      chk("bp in_ready",  int'(bus.in_ready_o),  0);
      chk("bp count",     int'(bus.count_o),     4);
      bus.in_valid_i = (k == 2);
      bus.data_i     = 16'hFFFF;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp release ready", int'(bus.in_ready_o), 1);
    chk("bp release count", int'(bus.count_o),    4);

    // Reset mid-scan
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.data_i     = 16'hAAAA;
    bus.overlap_i  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid rst in_ready",  int'(bus.in_ready_o),  1);
    chk("mid rst count",     int'(bus.count_o),     0);
    chk("mid rst bit_valid", int'(bus.bit_valid_o), 0);
    chk("mid rst det",       int'(bus.det_o),       0);
    chk("mid rst out_valid", int'(bus.out_valid_o), 0);
    run_word(16'h5555, 1'b1, 7, 16'hAAA8, "5555 after rst");

    // Back-to-back words with in_valid held high
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.data_i     = 16'hAAAA;
    bus.overlap_i  = 1'b1;
    acc_n = 0;
    for (int t = 0; t < 80 && acc_n < 3; t++) begin
      if (t > 0) @(negedge clk);
      if (bus.in_ready_o && bus.in_valid_i) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
        @(negedge clk);
        bus.data_i    = (acc_n == 1) ? 16'hA5A5 : 16'h5555;
        bus.overlap_i = (acc_n == 1) ? 1'b0 : 1'b1;
      end
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    chk("b2b accepts", acc_n, 3);
    if (acc_n == 3) begin
      chk("b2b gap 1", acc_cyc[1] - acc_cyc[0], W + 2);
      chk("b2b gap 2", acc_cyc[2] - acc_cyc[1], W + 2);
    end
    for (int k = 0; k < W + 4; k++) @(negedge clk);
    chk("final in_ready", int'(bus.in_ready_o), 1);
    chk("final count",    int'(bus.count_o),    7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
